// File: rtl/wired_fcc_iq_pkg.sv
// rtl/wired_fcc_iq_pkg.sv - shared wired0 types for the FCC issue queue
package wired0;

  localparam int FCC_RID_W = 6;

  typedef enum logic [2:0] {
    FCC_NOP      = 3'd0,
    FCC_FCMP     = 3'd1,
    FCC_FSEL     = 3'd2,
    FCC_MOVGR2CF = 3'd3,
    FCC_MOVCF2GR = 3'd4
  } fcc_op_e;

  typedef struct packed {
    fcc_op_e     op;
    logic [3:0]  cond;
    logic [2:0]  fcc_idx;
    logic [31:0] r0;
    logic [31:0] r1;
  } iq_fcc_req_t;

  typedef struct packed {
    logic                 valid;
    logic [FCC_RID_W-1:0] rid;
    logic [31:0]          data;
  } wkup_t;

  typedef struct packed {
    logic                       valid;
    iq_fcc_req_t                req;
    logic [1:0][FCC_RID_W-1:0]  rid;
    logic [1:0]                 rdy;
  } fcc_iq_entry_t;

  function automatic iq_fcc_req_t src_set(iq_fcc_req_t r, logic k, logic [31:0] d);
    iq_fcc_req_t o;
    o = r;
    if (k) o.r1 = d;
    else   o.r0 = d;
    return o;
  endfunction

endpackage

// File: rtl/wired_fcc_iq_entry.sv
// rtl/wired_fcc_iq_entry.sv - one issue-queue slot with wakeup tag compare and operand capture
module wired_fcc_iq_entry
  import wired0::*;
#(
  parameter int WKUP_NUM = 2,
  parameter int RID_W    = 6
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clr_i,
  input  logic                               wr_en_i,
  input  iq_fcc_req_t                        wr_req_i,
  input  logic [1:0][RID_W-1:0]              wr_rid_i,
  input  logic [1:0]                         wr_rdy_i,
  input  logic                               pop_i,
  input  logic [WKUP_NUM-1:0]                wkup_valid_i,
  input  logic [WKUP_NUM-1:0][RID_W-1:0]     wkup_rid_i,
  input  logic [WKUP_NUM-1:0][31:0]          wkup_data_i,
  output logic                               valid_o,
  output logic [1:0]                         rdy_o,
  output iq_fcc_req_t                        req_o
);

  fcc_iq_entry_t             ent_q, ent_d;
  wkup_t [WKUP_NUM-1:0]      wkup;
  logic [1:0]                hit_wr, hit_st;
  logic [1:0][31:0]          data_wr, data_st;

  always_comb begin
    for (int j = 0; j < WKUP_NUM; j++) begin
      wkup[j].valid = wkup_valid_i[j];
      wkup[j].rid   = wkup_rid_i[j];
      wkup[j].data  = wkup_data_i[j];
    end
  end

  // Scan from the highest bus down so the lowest matching bus is the last writer.
  always_comb begin
    hit_wr  = '0;
    hit_st  = '0;
    data_wr = '0;
    data_st = '0;
    for (int k = 0; k < 2; k++) begin
      for (int j = WKUP_NUM - 1; j >= 0; j--) begin
        if (wkup[j].valid && wkup[j].rid == wr_rid_i[k]) begin
          hit_wr[k]  = 1'b1;
          data_wr[k] = wkup[j].data;
        end
        if (wkup[j].valid && wkup[j].rid == ent_q.rid[k]) begin
          hit_st[k]  = 1'b1;
          data_st[k] = wkup[j].data;
        end
      end
    end
  end

  always_comb begin
    ent_d = ent_q;
    if (wr_en_i) begin
      ent_d.valid = 1'b1;
      ent_d.req   = wr_req_i;
      ent_d.rid   = wr_rid_i;
      ent_d.rdy   = wr_rdy_i | hit_wr;
      for (int k = 0; k < 2; k++) begin
        if (!wr_rdy_i[k] && hit_wr[k]) ent_d.req = src_set(ent_d.req, k[0], data_wr[k]);
      end
    end else if (pop_i) begin
      ent_d.valid = 1'b0;
    end else if (ent_q.valid) begin
      for (int k = 0; k < 2; k++) begin
        if (!ent_q.rdy[k] && hit_st[k]) begin
          ent_d.rdy[k] = 1'b1;
          ent_d.req    = src_set(ent_d.req, k[0], data_st[k]);
        end
      end
    end
  end

  // Only the valid bit is cleared; payload, tags and ready bits are don't-care when invalid.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      ent_q.valid <= 1'b0;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign valid_o = ent_q.valid;
  assign rdy_o   = ent_q.rdy;
  assign req_o   = ent_q.req;

endmodule

// File: rtl/wired_fcc_iq.sv
// rtl/wired_fcc_iq.sv - in-order issue queue feeding the FCC execution unit
module wired_fcc_iq
  import wired0::*;
#(
  parameter int DEPTH    = 4,
  parameter int WKUP_NUM = 2,
  parameter int RID_W    = 6
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush_i,
  input  logic                            disp_valid_i,
  output logic                            disp_ready_o,
  input  iq_fcc_req_t                     disp_req_i,
  input  logic [1:0][RID_W-1:0]           disp_rid_i,
  input  logic [1:0]                      disp_rdy_i,
  input  logic [WKUP_NUM-1:0]             wkup_valid_i,
  input  logic [WKUP_NUM-1:0][RID_W-1:0]  wkup_rid_i,
  input  logic [WKUP_NUM-1:0][31:0]       wkup_data_i,
  output logic                            ex_req_valid_o,
  input  logic                            ex_req_ready_i,
  output iq_fcc_req_t                     ex_req_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]       head_q, tail_q;
  logic [IDX_W-1:0]       head_idx, tail_idx;
  logic                   empty, full, push, pop;
  logic [DEPTH-1:0]       ent_valid;
  logic [DEPTH-1:0][1:0]  ent_rdy;
  iq_fcc_req_t            ent_req [DEPTH];

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];
  assign empty    = (head_q == tail_q);
  assign full     = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);

  // Ready depends on registered pointers only, so a pop never frees a slot in the same cycle.
  assign disp_ready_o   = !full;
  assign push           = disp_valid_i && !full && !flush_i;
  assign ex_req_valid_o = !empty && ent_valid[head_idx] && (&ent_rdy[head_idx]);
  assign pop            = ex_req_valid_o && ex_req_ready_i && !flush_i;
  assign ex_req_o       = ex_req_valid_o ? ent_req[head_idx] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    wired_fcc_iq_entry #(
      .WKUP_NUM (WKUP_NUM),
      .RID_W    (RID_W)
    ) u_entry (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr_i        (flush_i),
      .wr_en_i      (push && (tail_idx == IDX_W'(i))),
      .wr_req_i     (disp_req_i),
      .wr_rid_i     (disp_rid_i),
      .wr_rdy_i     (disp_rdy_i),
      .pop_i        (pop && (head_idx == IDX_W'(i))),
      .wkup_valid_i (wkup_valid_i),
      .wkup_rid_i   (wkup_rid_i),
      .wkup_data_i  (wkup_data_i),
      .valid_o      (ent_valid[i]),
      .rdy_o        (ent_rdy[i]),
      .req_o        (ent_req[i])
    );
  end

endmodule

// File: tb/tb_wired_fcc_iq.sv
// tb/tb_wired_fcc_iq.sv - directed self-checking bench for wired_fcc_iq
module tb_wired_fcc_iq;
  import wired0::*;

  localparam int DEPTH = 4, WKUP_NUM = 2, RID_W = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                            rst_n, flush_i, disp_valid_i, disp_ready_o;
  iq_fcc_req_t                     disp_req_i, ex_req_o;
  logic [1:0][RID_W-1:0]           disp_rid_i;
  logic [1:0]                      disp_rdy_i;
  logic [WKUP_NUM-1:0]             wkup_valid_i;
  logic [WKUP_NUM-1:0][RID_W-1:0]  wkup_rid_i;
  logic [WKUP_NUM-1:0][31:0]       wkup_data_i;
  logic                            ex_req_valid_o, ex_req_ready_i;

  wired_fcc_iq #(.DEPTH(DEPTH), .WKUP_NUM(WKUP_NUM), .RID_W(RID_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o), .disp_req_i(disp_req_i),
    .disp_rid_i(disp_rid_i), .disp_rdy_i(disp_rdy_i),
    .wkup_valid_i(wkup_valid_i), .wkup_rid_i(wkup_rid_i), .wkup_data_i(wkup_data_i),
    .ex_req_valid_o(ex_req_valid_o), .ex_req_ready_i(ex_req_ready_i), .ex_req_o(ex_req_o)
  );

  typedef struct {
    logic flush, dv;
    iq_fcc_req_t req;
    logic [5:0] rid0, rid1;
    logic [1:0] rdy, wv;
    logic [5:0] wrid0, wrid1;
    logic [31:0] wd0, wd1;
    logic er, e_dr, e_v;
    iq_fcc_req_t e_req;
  } vec_t;

  int checks = 0, errors = 0;
  vec_t vecs[$];
  iq_fcc_req_t mq[$];
  int pushed;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic iq_fcc_req_t mkreq(fcc_op_e op, logic [31:0] a, logic [31:0] b);
    iq_fcc_req_t r;
    r.op = op; r.cond = 4'h1; r.fcc_idx = 3'd2; r.r0 = a; r.r1 = b;
    return r;
  endfunction

  function automatic vec_t mkv(logic fl, logic dv, fcc_op_e op, logic [31:0] a, logic [31:0] b,
                               logic [5:0] r0, logic [5:0] r1, logic [1:0] rdy, logic [1:0] wv,
                               logic [5:0] w0, logic [31:0] d0, logic [5:0] w1, logic [31:0] d1,
                               logic er, logic e_dr, logic e_v, fcc_op_e e_op,
                               logic [31:0] e_a, logic [31:0] e_b);
    vec_t v;
    v.flush = fl; v.dv = dv; v.req = mkreq(op, a, b); v.rid0 = r0; v.rid1 = r1; v.rdy = rdy;
    v.wv = wv; v.wrid0 = w0; v.wd0 = d0; v.wrid1 = w1; v.wd1 = d1; v.er = er;
    v.e_dr = e_dr; v.e_v = e_v;
    v.e_req = e_v ? mkreq(e_op, e_a, e_b) : '0;
    return v;
  endfunction

  function automatic vec_t idle(logic e_v, fcc_op_e e_op, logic [31:0] e_a, logic [31:0] e_b);
    return mkv(0, 0, FCC_NOP, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 0, 0, 1, 1, e_v, e_op, e_a, e_b);
  endfunction

  task automatic drive(input vec_t v);
    flush_i = v.flush; disp_valid_i = v.dv; disp_req_i = v.req;
    disp_rid_i[0] = v.rid0; disp_rid_i[1] = v.rid1; disp_rdy_i = v.rdy;
    wkup_valid_i = v.wv; wkup_rid_i[0] = v.wrid0; wkup_rid_i[1] = v.wrid1;
    wkup_data_i[0] = v.wd0; wkup_data_i[1] = v.wd1; ex_req_ready_i = v.er;
  endtask

  // One cycle checked against a FIFO scoreboard of fully-ready entries.
  task automatic mcyc(input logic dv, input iq_fcc_req_t r, input logic er, input string tag);
    bit do_pop, do_push;
    vec_t v;
    v = mkv(0, dv, FCC_NOP, 0, 0, 6'd3, 6'd3, 2'b11, 2'b01, 6'd3, 32'hFFFF_FFFF, 0, 0, er, 0, 0, FCC_NOP, 0, 0);
    v.req = r;
    drive(v);
    #1;
    chk({tag, " disp_ready"}, 128'(disp_ready_o), 128'(mq.size() < DEPTH));
    chk({tag, " ex_valid"}, 128'(ex_req_valid_o), 128'(mq.size() > 0));
    chk({tag, " ex_req"}, 128'(ex_req_o), (mq.size() > 0) ? 128'(mq[0]) : 128'(0));
    do_pop  = (mq.size() > 0) && er;
    do_push = dv && (mq.size() < DEPTH);
    @(posedge clk); #1;
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin mq.push_back(r); pushed++; end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(idle(0, FCC_NOP, 0, 0));
    repeat (3) @(posedge clk);
    #1;
    chk("reset disp_ready", 128'(disp_ready_o), 128'(1));
    chk("reset ex_valid", 128'(ex_req_valid_o), 128'(0));
    chk("reset ex_req", 128'(ex_req_o), 128'(0));
    rst_n = 1'b1;

    // empty queue, ready op
    vecs.push_back(mkv(0, 1, FCC_FCMP, 32'h3F80_0000, 32'h4000_0000, 0, 0, 2'b11, 0, 0, 0, 0, 0, 1, 1, 0, FCC_NOP, 0, 0));
    vecs.push_back(idle(1, FCC_FCMP, 32'h3F80_0000, 32'h4000_0000));
    vecs.push_back(idle(0, FCC_NOP, 0, 0));
    // operand capture from bus 1
    vecs.push_back(mkv(0, 1, FCC_FSEL, 32'h1111_1111, 0, 0, 5, 2'b01, 0, 0, 0, 0, 0, 1, 1, 0, FCC_NOP, 0, 0));
    vecs.push_back(idle(0, FCC_NOP, 0, 0));
    vecs.push_back(idle(0, FCC_NOP, 0, 0));
    vecs.push_back(mkv(0, 0, FCC_NOP, 0, 0, 0, 0, 2'b11, 2'b11, 6, 32'h0, 5, 32'hDEAD_BEEF, 1, 1, 0, FCC_NOP, 0, 0));
    vecs.push_back(idle(1, FCC_FSEL, 32'h1111_1111, 32'hDEAD_BEEF));
    vecs.push_back(idle(0, FCC_NOP, 0, 0));
    // in-order blocking: A waits on rid 7, B ready behind it
    vecs.push_back(mkv(0, 1, FCC_FCMP, 0, 32'hA1, 7, 0, 2'b10, 0, 0, 0, 0, 0, 1, 1, 0, FCC_NOP, 0, 0));
    vecs.push_back(mkv(0, 1, FCC_MOVGR2CF, 32'hB0, 32'hB1, 0, 0, 2'b11, 0, 0, 0, 0, 0, 1, 1, 0, FCC_NOP, 0, 0));
    vecs.push_back(idle(0, FCC_NOP, 0, 0));
    vecs.push_back(mkv(0, 0, FCC_NOP, 0, 0, 0, 0, 2'b11, 2'b01, 7, 32'h77, 0, 0, 1, 1, 0, FCC_NOP, 0, 0));
    vecs.push_back(idle(1, FCC_FCMP, 32'h77, 32'hA1));
    vecs.push_back(idle(1, FCC_MOVGR2CF, 32'hB0, 32'hB1));
    vecs.push_back(idle(0, FCC_NOP, 0, 0));
    // dispatch-cycle bypass; both buses match, bus 0 wins
    vecs.push_back(mkv(0, 1, FCC_FCMP, 32'hBAD, 32'h22, 9, 0, 2'b10, 2'b11, 9, 32'h1, 9, 32'h2, 1, 1, 0, FCC_NOP, 0, 0));
    vecs.push_back(idle(1, FCC_FCMP, 32'h1, 32'h22));
    vecs.push_back(idle(0, FCC_NOP, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("vec%0d disp_ready", i), 128'(disp_ready_o), 128'(vecs[i].e_dr));
      chk($sformatf("vec%0d ex_valid", i), 128'(ex_req_valid_o), 128'(vecs[i].e_v));
      chk($sformatf("vec%0d ex_req", i), 128'(ex_req_o), 128'(vecs[i].e_req));
      @(posedge clk); #1;
    end

    // full, release, wrap over 3*DEPTH pushes; bus 0 keeps waking rid 3 on ready operands
    pushed = 0;
    for (int i = 0; i < DEPTH + 2; i++)
      mcyc(1'b1, mkreq(FCC_FCMP, 32'h100 + i, 32'h200 + i), 1'b0, $sformatf("fill%0d", i));
    mcyc(1'b1, mkreq(FCC_FSEL, 32'hEEEE, 32'hEEEE), 1'b1, "release");
    for (int c = 0; c < 8 * DEPTH && pushed < 3 * DEPTH; c++)
      mcyc(1'b1, mkreq(FCC_MOVCF2GR, 32'h300 + c, 32'h400 + c), (c % 3) != 0, $sformatf("wrap%0d", c));
    chk("wrap push count", 128'(pushed), 128'(3 * DEPTH));
    for (int c = 0; c < DEPTH + 2; c++)
      mcyc(1'b0, '0, 1'b1, $sformatf("drain%0d", c));

    // flush with a push and a pop handshake in the same cycle
    for (int i = 0; i < 3; i++)
      mcyc(1'b1, mkreq(FCC_FCMP, 32'h500 + i, 32'h600 + i), 1'b0, $sformatf("preflush%0d", i));
    drive(mkv(1, 1, FCC_FSEL, 32'h700, 32'h700, 0, 0, 2'b11, 0, 0, 0, 0, 0, 1, 1, 1, FCC_NOP, 0, 0));
    #1;
    chk("flush-cycle ex_valid", 128'(ex_req_valid_o), 128'(1));
    @(posedge clk); #1;
    mq.delete();
    for (int c = 0; c < 3; c++)
      mcyc(1'b0, '0, 1'b1, $sformatf("postflush%0d", c));
    mcyc(1'b1, mkreq(FCC_MOVGR2CF, 32'h800, 32'h900), 1'b1, "refill");
    mcyc(1'b0, '0, 1'b1, "refill_issue");
    mcyc(1'b0, '0, 1'b1, "refill_empty");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wired_fcc_iq.md
# wired_fcc_iq

In-order issue queue feeding the FCC execution unit (`wired_fcc`). It buffers FCC-class micro-ops in program order, captures missing source operands from the writeback/wakeup buses, and issues the oldest entry once both operands are present. Younger entries never bypass older ones, so `fcc` updates stay strictly ordered. A pipeline flush discards all buffered entries.

## Interface
Parameters:
- `DEPTH`, 4 — entries; power of two, ≥2.
- `WKUP_NUM`, 2 — number of wakeup/writeback buses.
- `RID_W`, 6 — physical register tag width.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset: synchronous, active-low.
- `flush_i`  in  1  pipeline flush; kills all entries.
- `disp_valid_i`  in  1  dispatch request.
- `disp_ready_o`  out  1  queue can accept (not full).
- `disp_req_i`  in  `iq_fcc_req_t`  op payload. `r0`/`r1` are valid only where the matching ready bit is set.
- `disp_rid_i`  in  2×`RID_W`  source tags for r0, r1.
- `disp_rdy_i`  in  2  source already present. An unused operand is dispatched as ready.
- `wkup_valid_i`  in  `WKUP_NUM`  wakeup broadcast valid.
- `wkup_rid_i`  in  `WKUP_NUM`×`RID_W`  produced tag.
- `wkup_data_i`  in  `WKUP_NUM`×32  produced value.
- `ex_req_valid_o`  out  1  head entry issuable.
- `ex_req_ready_i`  in  1  from `wired_fcc.ex_req_ready_o`.
- `ex_req_o`  out  `iq_fcc_req_t`  head payload with captured operands.

## Operation
- **Storage:** circular buffer of `DEPTH` entries.
  - Per entry: `valid`, payload, `rid[2]`, `rdy[2]`.
  - Pointers: `head` and `tail`, each `log2(DEPTH)+1` bits including a wrap bit.
  - Empty when head == tail. Full when the index bits match and the wrap bits differ.
- **Dispatch:** push fires on `disp_valid_i && disp_ready_o && !flush_i`.
  - The entry is written at `tail`, and `tail` increments.
  - `disp_ready_o = !full`. It is computed from registered state only; a same-cycle pop does not free a slot for a same-cycle push.
- **Wakeup:** for every valid entry and operand k with `!rdy[k]`:
  - If any `wkup_valid_i[j]` is set and `wkup_rid_i[j] == rid[k]`, write `wkup_data_i[j]` into r0 (k=0) or r1 (k=1) and set `rdy[k]`.
  - If several buses match, the lowest j wins.
- **Dispatch-cycle bypass:** a dispatching operand with `!disp_rdy_i[k]` whose tag matches a same-cycle wakeup is stored already ready, holding the wakeup data.
- **Issue:** `ex_req_valid_o = !empty && head.valid && &head.rdy`.
  - Pop fires on `ex_req_valid_o && ex_req_ready_i`; `head` increments and the entry's `valid` clears.
  - `ex_req_o` = head payload when `ex_req_valid_o`, else `'0`.
- **Flush:** `flush_i` has priority over push, pop and wakeup.
  - Next cycle: all `valid` = 0, head = tail = 0.
  - A push or pop in the flush cycle has no effect.
- **Reset:** same effect as flush. Reset output values:
  - `disp_ready_o` = 1
  - `ex_req_valid_o` = 0
  - `ex_req_o` = 0
  - Payload storage is not reset.

## Timing
- Dispatch to issue: earliest 1 cycle, when the entry is pushed ready into an empty queue.
- Wakeup to issue: 1 cycle. `rdy` is registered, and issue readiness uses registered `rdy` only.
- Issue rate: at most 1 per cycle, back-to-back when consecutive entries are ready.
- Queue full with a pop this cycle: `disp_ready_o` stays 0 this cycle and rises next cycle.
- Pointer wrap: index wraps modulo `DEPTH` and the wrap bit toggles. Full/empty detection must hold across wrap.
- Handshake hold: while `ex_req_valid_o && !ex_req_ready_i`, `ex_req_o` stays stable. A late wakeup cannot change it, because the head's operands are already ready.
- No combinational path from `ex_req_ready_i` to `disp_ready_o`.

## Structure
- In the shared `wired0` package:
  - `fcc_iq_entry_t` — valid, payload, rid, rdy.
  - `wkup_t` — valid, rid, data.
  - Reuse existing `iq_fcc_req_t`.
- One sub-module, `wired_fcc_iq_entry`: a single slot holding the entry register, the `WKUP_NUM`-way tag compare and the capture muxes. It is instantiated `DEPTH` times.
- The top level holds the pointers, full/empty logic and the head mux.

## Test plan
- **Empty queue, ready op:** dispatch a ready fcmp (r0=0x3F800000, r1=0x40000000) at cycle 0 with `ex_req_ready_i`=1 → `ex_req_valid_o`=1 at cycle 1 with the same operands; queue empty at cycle 2.
- **Operand capture:** dispatch fsel with r1 not ready, rid=5; at cycle 3 assert wakeup bus 1 with rid=5, data=0xDEADBEEF → issue at cycle 4 with `ex_req_o.r1`=0xDEADBEEF.
- **In-order blocking:** entry A waits on rid=7, entry B fully ready → B does not issue until A wakes and issues; order is A then B.
- **Full and wrap:** push `DEPTH` ready entries with `ex_req_ready_i`=0 → `disp_ready_o`=0. Release one → `disp_ready_o`=1 the following cycle. Push 3×`DEPTH` entries in total → issue order equals push order.
- **Flush mid-operation:** with 3 entries queued, assert `flush_i` together with `disp_valid_i` and a pop handshake → next cycle `ex_req_valid_o`=0, `disp_ready_o`=1, and nothing issues afterwards.
- **Dispatch-cycle bypass:** dispatch with r0 not ready, rid=9, while wakeup bus 0 carries rid=9, data=0x1 in the same cycle → entry issues next cycle with r0=0x1.
